pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow copy of destination/source tags for the ID/EX, EX/MEM and MEM/WB stages.
- Generates PC/IF-ID enables, ID/EX bubble injection, branch flushes and EX operand-forward selects.
- Keeps saturating stall/flush counters for bring-up.

Parameters:
- FWD_EN, 0, 1 = forward from EX/MEM and MEM/WB (stall only on load-use); 0 = stall until producer retires.
- WB_BYPASS, 0, 1 = regfile write-through (no hazard against MEM/WB); 0 = MEM/WB producer also stalls.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source register 1 of ID instruction
- id_rs2  in  5  source register 2
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  5  destination register
- id_wen  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- mem_pcsrc  in  1  branch/jump taken, resolved in MEM
- pc_en  out  1  advance PC
- if_id_en  out  1  load IF/ID
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP (all ctrl = 0) into ID/EX
- ex_mem_flush  out  1  clear EX/MEM control
- fwd_a_sel  out  2  EX operand A: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_b_sel  out  2  same for operand B
- state  out  2  FSM state
- stall_cnt  out  CNT_W  stall cycles, saturating
- flush_cnt  out  CNT_W  redirects, saturating

Behaviour:
- Shadow regs per stage: {valid, wen, rd, is_load, rs1, rs2}.
  - Advance every cycle: ID/EX <= ID inputs; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
  - On stall, ID/EX shadow loads valid=0/wen=0. Downstream stages keep advancing.
- Match(stage, rs): stage.valid & stage.wen & stage.rd==rs & rs!=0 & rs_used. x0 never hazards.
- Hazard, FWD_EN=0: match of rs1/rs2 against ID/EX or EX/MEM. MEM/WB is also checked when WB_BYPASS=0.
- Hazard, FWD_EN=1: ID/EX.is_load & match(ID/EX). This is load-use, exactly 1 stall cycle.
- stall = id_valid & hazard & !mem_pcsrc. Combinational, same cycle.
- Output relations:
  - pc_en = if_id_en = !stall.
  - id_ex_bubble = stall | mem_pcsrc.
  - if_id_flush = ex_mem_flush = mem_pcsrc.
  - pc_en = 1 on mem_pcsrc, so the PC loads the target.
- Branch beats stall on the same cycle: flush wins, stall_cnt does not increment.
  - Shadow ID/EX and EX/MEM become invalid next cycle.
- Forwarding (FWD_EN=1):
  - fwd_x_sel = 01 if match(EX/MEM, ID/EX.rsx) & !EX/MEM.is_load.
  - else 10 if match(MEM/WB, ID/EX.rsx).
  - else 00. EX/MEM has priority.
  - With FWD_EN=0, forward selects are tied to 00.
- FSM, registered:
  - RUN=0: stall -> HAZ; mem_pcsrc -> REDIR.
  - HAZ=1: mem_pcsrc -> REDIR; !stall -> RUN.
  - REDIR=2: one cycle, then RUN, or HAZ if stall.
  - Value 3 is unused; it decodes to RUN.
- Counters:
  - stall_cnt += 1 per stall cycle; flush_cnt += 1 per mem_pcsrc cycle.
  - Both hold at all-ones.
- Reset (rst=1 at posedge) has priority over everything:
  - All shadow valid=0, state=RUN, counters=0.
  - Outputs after reset: pc_en=if_id_en=1, flushes/bubble=0, fwd_sel=00.
- Reset mid-stall: the stall drops next cycle, because the shadows are cleared.

Decomposition:
- Shared package pipe_pkg:
  - state enum {ST_RUN, ST_HAZ, ST_REDIR}
  - FWD_REGFILE/FWD_EXMEM/FWD_MEMWB constants
  - stage tag struct
- One sub-module, hazard_tag_match: rd/rs/wen/valid compare with the x0 exclusion. Instantiated per stage/source pair.

Test Plan:
- FWD_EN=0, WB_BYPASS=0: addi x5 then add x6,x5,x1 back-to-back.
  - Expect stall=1 for exactly 3 cycles, then RUN.
  - Expect stall_cnt=3 and 3 bubbles reach ID/EX.
- FWD_EN=1: lw x7 then add x8,x7,x7.
  - Expect 1 stall cycle.
  - Next cycle fwd_a_sel=fwd_b_sel=10; stall_cnt=1.
- FWD_EN=1: add x3 then sub x4,x3,x2 then or x9,x3,x3.
  - Expect no stall.
  - sub gets fwd_a_sel=01.
  - or gets fwd_a_sel=fwd_b_sel=10.
- Hazard present with mem_pcsrc=1 in the same cycle.
  - Expect stall=0, all three flushes/bubble=1, pc_en=1.
  - state=REDIR then RUN; flush_cnt=1, stall_cnt unchanged.
- Writes to x0 or id_rs1_used=0 with a matching tag -> never stall.
- rst asserted during HAZ -> next cycle state=RUN, counters=0, pc_en=1. Preload stall_cnt near all-ones -> holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned ST_W  = 2;

    // Controller sequencing states; encoding 3 is unused and decodes to RUN.
    typedef enum logic [ST_W-1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    // EX operand source selects.
    localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM   = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEMWB   = 2'b10;

    // Shadow tag carried alongside each pipeline stage.
    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] rd;
        logic             is_load;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } stage_tag_t;

    localparam stage_tag_t TAG_NONE = '0;

endpackage

// File: rtl/hazard_tag_match.sv
// Producer/consumer register tag compare; x0 never produces a hazard.
module hazard_tag_match
    import pipe_pkg::*;
(
    input  logic             valid,
    input  logic             wen,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic             rs_used,
    output logic             match_c
);

    // A live writer of a non-zero register that the consumer actually reads.
    assign match_c = valid & wen & rs_used & (rs != '0) & (rd == rs);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, stall/flush sequencing and EX forwarding for a 5-stage RV32I pipe.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit          FWD_EN    = 1'b0,
    parameter bit          WB_BYPASS = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             mem_pcsrc,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [FWD_W-1:0] fwd_a_sel,
    output logic [FWD_W-1:0] fwd_b_sel,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned N_STG = 3;  // 0: ID/EX, 1: EX/MEM, 2: MEM/WB
    localparam int unsigned N_SRC = 2;

    stage_tag_t       shd_q [N_STG];
    stage_tag_t       id_tag;
    state_e           state_q;
    logic [REG_W-1:0] id_rs   [N_SRC];
    logic             id_used [N_SRC];
    logic [REG_W-1:0] ex_rs   [N_SRC];
    logic [N_STG*N_SRC-1:0] hz_m;
    logic [(N_STG-1)*N_SRC-1:0] fw_m;
    logic             hazard_c;
    logic             stall_c;
    logic             unused_tag_bits;

    // Pack the ID-stage instruction into a shadow tag.
    always_comb begin
        id_tag         = TAG_NONE;
        id_tag.valid   = id_valid;
        id_tag.wen     = id_wen;
        id_tag.rd      = id_rd;
        id_tag.is_load = id_is_load;
        id_tag.rs1     = id_rs1;
        id_tag.rs2     = id_rs2;
    end

    assign id_rs[0]   = id_rs1;
    assign id_rs[1]   = id_rs2;
    assign id_used[0] = id_rs1_used;
    assign id_used[1] = id_rs2_used;
    assign ex_rs[0]   = shd_q[0].rs1;
    assign ex_rs[1]   = shd_q[0].rs2;

    // ID sources against every downstream producer.
    for (genvar s = 0; s < N_STG; s++) begin : g_hz_stg
        for (genvar r = 0; r < N_SRC; r++) begin : g_hz_src
            hazard_tag_match u_hz (
                .valid   (shd_q[s].valid),
                .wen     (shd_q[s].wen),
                .rd      (shd_q[s].rd),
                .rs      (id_rs[r]),
                .rs_used (id_used[r]),
                .match_c (hz_m[s*N_SRC+r])
            );
        end
    end

    // EX consumer sources against EX/MEM and MEM/WB producers.
    for (genvar s = 1; s < N_STG; s++) begin : g_fw_stg
        for (genvar r = 0; r < N_SRC; r++) begin : g_fw_src
            hazard_tag_match u_fw (
                .valid   (shd_q[s].valid),
                .wen     (shd_q[s].wen),
                .rd      (shd_q[s].rd),
                .rs      (ex_rs[r]),
                .rs_used (shd_q[0].valid),
                .match_c (fw_m[(s-1)*N_SRC+r])
            );
        end
    end

    // Hazard window depends on whether results can be forwarded.
    always_comb begin
        hazard_c = 1'b0;
        if (FWD_EN) begin
            hazard_c = shd_q[0].is_load & (|hz_m[1:0]);
        end else begin
            hazard_c = (|hz_m[1:0]) | (|hz_m[3:2]) | (~WB_BYPASS & (|hz_m[5:4]));
        end
    end

    // A taken branch squashes the stalled instruction, so it overrides the stall.
    assign stall_c      = id_valid & hazard_c & ~mem_pcsrc;
    assign pc_en        = ~stall_c;
    assign if_id_en     = ~stall_c;
    assign id_ex_bubble = stall_c | mem_pcsrc;
    assign if_id_flush  = mem_pcsrc;
    assign ex_mem_flush = mem_pcsrc;

    // EX operand selects; the younger EX/MEM result wins unless it is still a load.
    always_comb begin
        fwd_a_sel = FWD_REGFILE;
        fwd_b_sel = FWD_REGFILE;
        if (FWD_EN) begin
            if (fw_m[0] & ~shd_q[1].is_load) fwd_a_sel = FWD_EXMEM;
            else if (fw_m[2])                fwd_a_sel = FWD_MEMWB;
            if (fw_m[1] & ~shd_q[1].is_load) fwd_b_sel = FWD_EXMEM;
            else if (fw_m[3])                fwd_b_sel = FWD_MEMWB;
        end
    end

    // Shadow tag pipeline; bubbles and flushes kill the tag, later stages keep moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STG; i++) shd_q[i] <= TAG_NONE;
        end else begin
            shd_q[0] <= id_tag;
            if (id_ex_bubble) begin
                shd_q[0].valid <= 1'b0;
                shd_q[0].wen   <= 1'b0;
            end
            shd_q[1] <= shd_q[0];
            if (ex_mem_flush) begin
                shd_q[1].valid <= 1'b0;
                shd_q[1].wen   <= 1'b0;
            end
            shd_q[2] <= shd_q[1];
        end
    end

    // Sequencing state: a redirect dominates, otherwise track the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_HAZ: begin
                    if (mem_pcsrc)     state_q <= ST_REDIR;
                    else if (!stall_c) state_q <= ST_RUN;
                    else               state_q <= ST_HAZ;
                end
                ST_REDIR: begin
                    if (mem_pcsrc)     state_q <= ST_REDIR;
                    else if (stall_c)  state_q <= ST_HAZ;
                    else               state_q <= ST_RUN;
                end
                default: begin
                    if (stall_c)        state_q <= ST_HAZ;
                    else if (mem_pcsrc) state_q <= ST_REDIR;
                    else                state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign state = state_q;

    // Saturating bring-up counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_c && (stall_cnt != '1))   stall_cnt <= stall_cnt + CNT_W'(1);
            if (mem_pcsrc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Tag fields carried for debug visibility but not consumed downstream.
    assign unused_tag_bits = ^{shd_q[1].rs1, shd_q[1].rs2,
                               shd_q[2].is_load, shd_q[2].rs1, shd_q[2].rs2};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an in-flight-window reference model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic       pcsrc;
    } drv_t;

    typedef struct packed {
        bit       v;
        bit       w;
        bit [4:0] rd;
        bit       ld;
        bit [4:0] rs1;
        bit [4:0] rs2;
    } mtag_t;

    // Instance configurations: u0 no forwarding, u1 forwarding, u2 write-through + 4-bit counters.
    localparam bit P_FWD [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit P_WBB [3] = '{1'b0, 1'b0, 1'b1};
    localparam int P_MAX [3] = '{65535, 65535, 15};

    logic clk = 1'b0;
    logic rst;
    drv_t drv [3];

    logic       o_pc [3], o_ifen [3], o_iff [3], o_bub [3], o_exf [3];
    logic [1:0] o_fa [3], o_fb [3], o_st [3];
    logic [15:0] o_sc0, o_sc1, o_fc0, o_fc1;
    logic [3:0]  o_sc2, o_fc2;

    // Model: tags of instructions that entered EX 1, 2, 3 cycles ago (index = age).
    mtag_t m_tag [3][3];
    int    m_state [3];
    int    m_sc [3];
    int    m_fc [3];

    int  checks = 0;
    int  errors = 0;
    int  bub0   = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .id_valid(drv[0].valid), .id_rs1(drv[0].rs1), .id_rs2(drv[0].rs2),
        .id_rs1_used(drv[0].u1), .id_rs2_used(drv[0].u2), .id_rd(drv[0].rd), .id_wen(drv[0].wen),
        .id_is_load(drv[0].ld), .mem_pcsrc(drv[0].pcsrc), .pc_en(o_pc[0]), .if_id_en(o_ifen[0]),
        .if_id_flush(o_iff[0]), .id_ex_bubble(o_bub[0]), .ex_mem_flush(o_exf[0]),
        .fwd_a_sel(o_fa[0]), .fwd_b_sel(o_fb[0]), .state(o_st[0]), .stall_cnt(o_sc0), .flush_cnt(o_fc0));

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .WB_BYPASS(1'b0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_valid(drv[1].valid), .id_rs1(drv[1].rs1), .id_rs2(drv[1].rs2),
        .id_rs1_used(drv[1].u1), .id_rs2_used(drv[1].u2), .id_rd(drv[1].rd), .id_wen(drv[1].wen),
        .id_is_load(drv[1].ld), .mem_pcsrc(drv[1].pcsrc), .pc_en(o_pc[1]), .if_id_en(o_ifen[1]),
        .if_id_flush(o_iff[1]), .id_ex_bubble(o_bub[1]), .ex_mem_flush(o_exf[1]),
        .fwd_a_sel(o_fa[1]), .fwd_b_sel(o_fb[1]), .state(o_st[1]), .stall_cnt(o_sc1), .flush_cnt(o_fc1));

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b1), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .id_valid(drv[2].valid), .id_rs1(drv[2].rs1), .id_rs2(drv[2].rs2),
        .id_rs1_used(drv[2].u1), .id_rs2_used(drv[2].u2), .id_rd(drv[2].rd), .id_wen(drv[2].wen),
        .id_is_load(drv[2].ld), .mem_pcsrc(drv[2].pcsrc), .pc_en(o_pc[2]), .if_id_en(o_ifen[2]),
        .if_id_flush(o_iff[2]), .id_ex_bubble(o_bub[2]), .ex_mem_flush(o_exf[2]),
        .fwd_a_sel(o_fa[2]), .fwd_b_sel(o_fb[2]), .state(o_st[2]), .stall_cnt(o_sc2), .flush_cnt(o_fc2));

    function automatic logic [31:0] get_sc(int k);
        case (k)
            0:       return 32'(o_sc0);
            1:       return 32'(o_sc1);
            default: return 32'(o_sc2);
        endcase
    endfunction

    function automatic logic [31:0] get_fc(int k);
        case (k)
            0:       return 32'(o_fc0);
            1:       return 32'(o_fc1);
            default: return 32'(o_fc2);
        endcase
    endfunction

    task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got %0h expected %0h", k, nm, act, exp);
        end
    endtask

    function automatic bit mmatch(mtag_t t, bit [4:0] rs, bit used);
        return t.v && t.w && used && (rs != 5'd0) && (t.rd == rs);
    endfunction

    // A producer younger than the retire point blocks the ID instruction.
    function automatic bit exp_stall(int k);
        bit haz = 1'b0;
        int depth;
        if (P_FWD[k]) begin
            haz = m_tag[k][0].ld && (mmatch(m_tag[k][0], drv[k].rs1, drv[k].u1) ||
                                     mmatch(m_tag[k][0], drv[k].rs2, drv[k].u2));
        end else begin
            depth = P_WBB[k] ? 2 : 3;
            for (int a = 0; a < depth; a++)
                if (mmatch(m_tag[k][a], drv[k].rs1, drv[k].u1) ||
                    mmatch(m_tag[k][a], drv[k].rs2, drv[k].u2)) haz = 1'b1;
        end
        return drv[k].valid && haz && !drv[k].pcsrc;
    endfunction

    function automatic logic [1:0] exp_fwd(int k, bit [4:0] rs);
        bit used = m_tag[k][0].v;
        if (!P_FWD[k]) return 2'd0;
        if (mmatch(m_tag[k][1], rs, used) && !m_tag[k][1].ld) return 2'd1;
        if (mmatch(m_tag[k][2], rs, used)) return 2'd2;
        return 2'd0;
    endfunction

    // Every-cycle compare, then advance the model to what the next edge produces.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit st;
            bit pc;
            st = exp_stall(k);
            pc = drv[k].pcsrc;
            if (chk_en) begin
                chk(k, "pc_en",        32'(o_pc[k]),  32'(!st));
                chk(k, "if_id_en",     32'(o_ifen[k]), 32'(!st));
                chk(k, "if_id_flush",  32'(o_iff[k]), 32'(pc));
                chk(k, "id_ex_bubble", 32'(o_bub[k]), 32'(st || pc));
                chk(k, "ex_mem_flush", 32'(o_exf[k]), 32'(pc));
                chk(k, "fwd_a_sel",    32'(o_fa[k]),  32'(exp_fwd(k, m_tag[k][0].rs1)));
                chk(k, "fwd_b_sel",    32'(o_fb[k]),  32'(exp_fwd(k, m_tag[k][0].rs2)));
                chk(k, "state",        32'(o_st[k]),  32'(m_state[k]));
                chk(k, "stall_cnt",    get_sc(k),     32'(m_sc[k]));
                chk(k, "flush_cnt",    get_fc(k),     32'(m_fc[k]));
                if (k == 0 && o_bub[0] === 1'b1) bub0++;
            end
            if (rst) begin
                for (int a = 0; a < 3; a++) m_tag[k][a] = '0;
                m_state[k] = 0;
                m_sc[k]    = 0;
                m_fc[k]    = 0;
            end else begin
                m_state[k] = pc ? 2 : (st ? 1 : 0);
                if (st && m_sc[k] < P_MAX[k]) m_sc[k]++;
                if (pc && m_fc[k] < P_MAX[k]) m_fc[k]++;
                m_tag[k][2] = m_tag[k][1];
                m_tag[k][1] = pc ? mtag_t'('0) : m_tag[k][0];
                m_tag[k][0] = (st || pc) ? mtag_t'('0) :
                              {1'b1 & drv[k].valid, drv[k].wen, drv[k].rd, drv[k].ld, drv[k].rs1, drv[k].rs2};
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        drv[k] = '0;
    endtask

    task automatic put(int k, bit [4:0] rd, bit wen, bit ld, bit [4:0] rs1, bit u1,
                       bit [4:0] rs2, bit u2, bit pc);
        drv[k].valid = 1'b1;
        drv[k].rd    = rd;
        drv[k].wen   = wen;
        drv[k].ld    = ld;
        drv[k].rs1   = rs1;
        drv[k].u1    = u1;
        drv[k].rs2   = rs2;
        drv[k].u2    = u2;
        drv[k].pcsrc = pc;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) idle(k);
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk(0, "rst_pc_en", 32'(o_pc[0]), 32'd1);
        chk(0, "rst_state", 32'(o_st[0]), 32'd0);
        chk(0, "rst_stall_cnt", get_sc(0), 32'd0);
        chk(1, "rst_fwd_a", 32'(o_fa[1]), 32'd0);

        // No forwarding: addi x5,x1 ; add x6,x5,x1 -> three stall cycles.
        cyc(); put(0, 5'd5, 1, 0, 5'd1, 1, 5'd0, 0, 0);
        cyc(); put(0, 5'd6, 1, 0, 5'd5, 1, 5'd1, 1, 0);
        @(negedge clk); chk(0, "t1_stall_pc_en", 32'(o_pc[0]), 32'd0);
        cyc();
        @(negedge clk); chk(0, "t1_state_haz", 32'(o_st[0]), 32'd1);
        cyc();
        cyc();
        @(negedge clk); chk(0, "t1_release_pc_en", 32'(o_pc[0]), 32'd1);
        cyc(); idle(0);
        @(negedge clk);
        chk(0, "t1_state_run", 32'(o_st[0]), 32'd0);
        chk(0, "t1_stall_cnt", get_sc(0), 32'd3);
        chk(0, "t1_bubbles", 32'(bub0), 32'd3);

        // Forwarding: lw x7 ; add x8,x7,x7 -> one load-use stall, then MEM/WB forward.
        cyc(); put(1, 5'd7, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        cyc(); put(1, 5'd8, 1, 0, 5'd7, 1, 5'd7, 1, 0);
        @(negedge clk); chk(1, "t2_stall_pc_en", 32'(o_pc[1]), 32'd0);
        cyc();
        @(negedge clk); chk(1, "t2_release_pc_en", 32'(o_pc[1]), 32'd1);
        cyc(); idle(1);
        @(negedge clk);
        chk(1, "t2_fwd_a", 32'(o_fa[1]), 32'd2);
        chk(1, "t2_fwd_b", 32'(o_fb[1]), 32'd2);
        chk(1, "t2_stall_cnt", get_sc(1), 32'd1);

        // Forwarding: add x3 ; sub x4,x3,x2 ; or x9,x3,x3 -> no stall.
        cyc(); put(1, 5'd3, 1, 0, 5'd1, 1, 5'd2, 1, 0);
        cyc(); put(1, 5'd4, 1, 0, 5'd3, 1, 5'd2, 1, 0);
        @(negedge clk); chk(1, "t3_sub_no_stall", 32'(o_pc[1]), 32'd1);
        cyc(); put(1, 5'd9, 1, 0, 5'd3, 1, 5'd3, 1, 0);
        @(negedge clk);
        chk(1, "t3_or_no_stall", 32'(o_pc[1]), 32'd1);
        chk(1, "t3_sub_fwd_a", 32'(o_fa[1]), 32'd1);
        chk(1, "t3_sub_fwd_b", 32'(o_fb[1]), 32'd0);
        cyc(); idle(1);
        @(negedge clk);
        chk(1, "t3_or_fwd_a", 32'(o_fa[1]), 32'd2);
        chk(1, "t3_or_fwd_b", 32'(o_fb[1]), 32'd2);

        // Hazard and taken branch in the same cycle: the flush wins.
        cyc(); put(0, 5'd5, 1, 0, 5'd1, 1, 5'd0, 0, 0);
        cyc(); put(0, 5'd6, 1, 0, 5'd5, 1, 5'd1, 1, 1);
        @(negedge clk);
        chk(0, "t4_pc_en", 32'(o_pc[0]), 32'd1);
        chk(0, "t4_if_id_flush", 32'(o_iff[0]), 32'd1);
        chk(0, "t4_bubble", 32'(o_bub[0]), 32'd1);
        chk(0, "t4_ex_mem_flush", 32'(o_exf[0]), 32'd1);
        cyc(); idle(0);
        @(negedge clk); chk(0, "t4_state_redir", 32'(o_st[0]), 32'd2);
        cyc();
        @(negedge clk);
        chk(0, "t4_state_run", 32'(o_st[0]), 32'd0);
        chk(0, "t4_flush_cnt", get_fc(0), 32'd1);
        chk(0, "t4_stall_cnt", get_sc(0), 32'd3);

        // x0 destinations and unused sources never stall.
        cyc(); put(0, 5'd0, 1, 0, 5'd1, 1, 5'd0, 0, 0);
        cyc(); put(0, 5'd1, 1, 0, 5'd0, 1, 5'd0, 1, 0);
        @(negedge clk); chk(0, "t5_x0_no_stall", 32'(o_pc[0]), 32'd1);
        cyc(); put(0, 5'd5, 1, 0, 5'd1, 1, 5'd0, 0, 0);
        cyc(); put(0, 5'd6, 1, 0, 5'd5, 0, 5'd6, 1, 0);
        @(negedge clk); chk(0, "t5_unused_no_stall", 32'(o_pc[0]), 32'd1);
        cyc(); idle(0);

        // Narrow counter: 16 stall cycles saturate a 4-bit counter at 15.
        for (int i = 0; i < 8; i++) begin
            cyc(); put(2, 5'd5, 1, 0, 5'd1, 1, 5'd0, 0, 0);
            cyc(); put(2, 5'd6, 1, 0, 5'd5, 1, 5'd0, 0, 0);
            cyc();
            cyc();
            cyc(); idle(2);
        end
        cyc();
        @(negedge clk); chk(2, "t6_stall_cnt_sat", get_sc(2), 32'hF);

        // Reset while stalled: state, counters and stall all clear.
        cyc(); put(0, 5'd5, 1, 0, 5'd1, 1, 5'd0, 0, 0);
        cyc(); put(0, 5'd6, 1, 0, 5'd5, 1, 5'd0, 0, 0);
        cyc(); rst = 1'b1;
        @(negedge clk); chk(0, "t7_state_haz", 32'(o_st[0]), 32'd1);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk(0, "t7_state_run", 32'(o_st[0]), 32'd0);
        chk(0, "t7_stall_cnt", get_sc(0), 32'd0);
        chk(0, "t7_flush_cnt", get_fc(0), 32'd0);
        chk(0, "t7_pc_en", 32'(o_pc[0]), 32'd1);
        chk(2, "t7_u2_stall_cnt", get_sc(2), 32'd0);
        cyc(); idle(0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
